// File: rtl/pixel_line_buffer.sv
// Double-banked pixel line buffer: upstream fills one bank while the LED controller
// reads the other; banks exchange on a display-side swap strobe once a line is complete.
module pixel_line_buffer #(
  parameter int PX_NUM         = 48,
  parameter int PX_COUNT_WIDTH = 6,
  parameter int BITS_PER_PIXEL = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [BITS_PER_PIXEL-1:0] wr_data,
  input  logic                      wr_last,
  input  logic                      swap_req,
  input  logic [PX_COUNT_WIDTH-1:0] next_px_num,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic [15:0]               line_count,
  output logic                      underrun
);

  localparam int LEN_W  = PX_COUNT_WIDTH + 1;
  localparam int ADDR_W = $clog2(2 * PX_NUM);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                      state_reg, state_next;
  logic [PX_COUNT_WIDTH-1:0]   wr_idx_reg;
  logic                        wr_bank_reg;
  logic [LEN_W-1:0]            rd_len_reg;
  logic [LEN_W-1:0]            wr_len_reg;
  logic [15:0]                 line_count_reg;
  logic                        underrun_reg;
  logic                        ready_reg;
  logic                        rd_hit_reg;
  logic [BITS_PER_PIXEL-1:0]   ram_q_reg;

  // Both banks live in one array: bank b occupies [b*PX_NUM, b*PX_NUM+PX_NUM-1].
  logic [BITS_PER_PIXEL-1:0]   mem [0:2*PX_NUM-1];

  logic                        accept;
  logic                        line_done;
  logic                        do_swap;
  logic                        rd_hit;
  logic [ADDR_W-1:0]           wr_addr;
  logic [ADDR_W-1:0]           rd_addr;

  assign accept    = wr_valid && ready_reg;
  assign line_done = accept && (wr_last || (wr_idx_reg == PX_COUNT_WIDTH'(PX_NUM - 1)));
  assign do_swap   = (state_reg == FULL) && swap_req;

  assign rd_hit  = ({1'b0, next_px_num} < rd_len_reg) &&
                   ({1'b0, next_px_num} < LEN_W'(PX_NUM));
  assign wr_addr = ADDR_W'(wr_idx_reg) + (wr_bank_reg ? ADDR_W'(PX_NUM) : '0);
  assign rd_addr = rd_hit ? (ADDR_W'(next_px_num) + (wr_bank_reg ? '0 : ADDR_W'(PX_NUM)))
                          : '0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (line_done) state_next = FULL;
      FULL:    if (swap_req)  state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= FILL;
      wr_idx_reg     <= '0;
      wr_bank_reg    <= 1'b1;
      rd_len_reg     <= '0;
      wr_len_reg     <= '0;
      line_count_reg <= '0;
      underrun_reg   <= 1'b0;
      ready_reg      <= 1'b0;
      rd_hit_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      // Registered ready tracks the next state, so it never depends on wr_valid combinationally.
      ready_reg  <= (state_next == FILL);
      rd_hit_reg <= rd_hit;
      if (accept) begin
        wr_idx_reg <= wr_idx_reg + PX_COUNT_WIDTH'(1);
        if (line_done) wr_len_reg <= LEN_W'(wr_idx_reg) + LEN_W'(1);
      end
      if (do_swap) begin
        wr_bank_reg    <= ~wr_bank_reg;
        wr_idx_reg     <= '0;
        rd_len_reg     <= wr_len_reg;
        line_count_reg <= line_count_reg + 16'd1;
      end
      if (swap_req && (state_reg == FILL)) underrun_reg <= 1'b1;
    end
  end

  // Plain RAM ports without reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= wr_data;
    ram_q_reg <= mem[rd_addr];
  end

  assign pixel      = rd_hit_reg ? ram_q_reg : '0;
  assign wr_ready   = ready_reg;
  assign line_count = line_count_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_pixel_line_buffer.sv
// Directed self-checking bench for pixel_line_buffer: fill/swap/read sweeps, short
// lines, underrun, overlong input without wr_last, and mid-line asynchronous reset.
module tb_pixel_line_buffer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [23:0] wr_data;
  logic        wr_last;
  logic        swap_req;
  logic [5:0]  next_px_num;
  logic [23:0] pixel;
  logic [15:0] line_count;
  logic        underrun;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_line [0:63];

  pixel_line_buffer #(.PX_NUM(48), .PX_COUNT_WIDTH(6), .BITS_PER_PIXEL(24)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_last(wr_last), .swap_req(swap_req),
    .next_px_num(next_px_num), .pixel(pixel), .line_count(line_count),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [23:0] data, input logic last);
    check("wr_ready_before_write", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = data;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 48; i++) begin
      next_px_num = 6'(i);
      tick();
      check(tag, {8'd0, pixel}, exp_line[i]);
    end
    next_px_num = 6'd63;
    tick();
    check({tag, "_idx63"}, {8'd0, pixel}, 32'd0);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_line[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
    swap_req = 1'b0; next_px_num = '0;
    repeat (3) tick();
    check("rst_pixel",      {8'd0, pixel},       32'd0);
    check("rst_line_count", {16'd0, line_count}, 32'd0);
    check("rst_underrun",   {31'd0, underrun},   32'd0);
    check("rst_wr_ready",   {31'd0, wr_ready},   32'd0);

    // Empty read bank shows black; ready comes up one edge after release.
    reset_n = 1'b1;
    tick();
    check("ready_after_release", {31'd0, wr_ready}, 32'd1);
    clear_exp();
    sweep("empty_sweep");

    // Full 48-word ramp line.
    for (int i = 0; i < 48; i++) write_word(24'(32'h010000 * i), i == 47);
    check("ready_low_when_full", {31'd0, wr_ready}, 32'd0);
    do_swap();
    check("ready_after_swap1", {31'd0, wr_ready},   32'd1);
    check("line_count_1",      {16'd0, line_count}, 32'd1);
    for (int i = 0; i < 48; i++) exp_line[i] = 32'h010000 * i;
    sweep("ramp_sweep");

    // Short white line of 10 words.
    for (int i = 0; i < 10; i++) write_word(24'hFFFFFF, i == 9);
    do_swap();
    check("line_count_2", {16'd0, line_count}, 32'd2);
    clear_exp();
    for (int i = 0; i < 10; i++) exp_line[i] = 32'hFFFFFF;
    sweep("short_sweep");

    // Swap while still filling: underrun, no swap.
    do_swap();
    check("underrun_set",        {31'd0, underrun},   32'd1);
    check("line_count_held",     {16'd0, line_count}, 32'd2);
    check("ready_after_underrun", {31'd0, wr_ready},  32'd1);
    next_px_num = 6'd3;  tick();
    check("old_line_idx3", {8'd0, pixel}, 32'hFFFFFF);
    next_px_num = 6'd20; tick();
    check("old_line_idx20", {8'd0, pixel}, 32'd0);
    for (int i = 0; i < 8; i++) write_word(24'h00AA00 + 24'(i), i == 7);
    do_swap();
    check("line_count_3",    {16'd0, line_count}, 32'd3);
    check("underrun_sticky", {31'd0, underrun},   32'd1);
    clear_exp();
    for (int i = 0; i < 8; i++) exp_line[i] = 32'h00AA00 + i;
    sweep("aa_sweep");

    // 60 cycles of valid data without wr_last: only 48 accepted.
    accepted = 0;
    wr_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      wr_data = 24'h100000 + 24'(accepted);
      if (wr_ready) accepted++;
      tick();
    end
    wr_valid = 1'b0;
    check("accepted_48",       32'(accepted),      32'd48);
    check("ready_low_overrun", {31'd0, wr_ready},  32'd0);
    repeat (3) tick();
    check("ready_low_idle",    {31'd0, wr_ready},  32'd0);
    next_px_num = 6'd5;
    tick();
    check("idx5_before_swap", {8'd0, pixel}, 32'h00AA05);
    do_swap();
    check("idx5_on_swap_edge", {8'd0, pixel}, 32'h00AA05);
    check("line_count_4",      {16'd0, line_count}, 32'd4);
    tick();
    check("idx5_after_swap",   {8'd0, pixel}, 32'h100005);

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 20; i++) write_word(24'h0F0F00 + 24'(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pixel",      {8'd0, pixel},       32'd0);
    check("async_rst_line_count", {16'd0, line_count}, 32'd0);
    check("async_rst_underrun",   {31'd0, underrun},   32'd0);
    check("async_rst_wr_ready",   {31'd0, wr_ready},   32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("ready_after_rerelease", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i < 48; i++) write_word(24'h300000 + 24'(i), i == 47);
    do_swap();
    check("line_count_after_rst", {16'd0, line_count}, 32'd1);
    for (int i = 0; i < 48; i++) exp_line[i] = 32'h300000 + i;
    sweep("post_rst_sweep");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_line_buffer.md
PIXEL_LINE_BUFFER -- requirements
Module: pixel_line_buffer

Interface
REQ-001 Parameter PX_NUM, default 48: LEDs per line (strip length).
REQ-002 Parameter PX_COUNT_WIDTH, default 6: width of the pixel index; 2^PX_COUNT_WIDTH SHALL be >= PX_NUM.
REQ-003 Parameter BITS_PER_PIXEL, default 24: pixel word width, GRB order, passed through untouched.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge, except for reset.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_valid  in  1  upstream pixel word valid.
REQ-007 wr_ready  out  1  buffer accepts a word this cycle.
REQ-008 wr_data  in  BITS_PER_PIXEL  pixel word, written at the current write index.
REQ-009 wr_last  in  1  marks the final word of a line.
REQ-010 swap_req  in  1  single-cycle line-boundary strobe from the display side.
REQ-011 next_px_num  in  PX_COUNT_WIDTH  pixel index requested by the neopixel controller.
REQ-012 pixel  out  BITS_PER_PIXEL  registered colour for next_px_num.
REQ-013 line_count  out  16  number of completed bank swaps; wraps at 2^16.
REQ-014 underrun  out  1  sticky flag: a swap_req arrived while no complete line was ready.

Function
REQ-015 The block SHALL hold two banks of PX_NUM words: a read bank (displayed) and a write bank (filling).
REQ-016 The write side SHALL be a two-state FSM: FILL and FULL.
REQ-017 In FILL, wr_ready SHALL be 1; in FULL, and while reset_n is low, it SHALL be 0.
REQ-018 A word SHALL be accepted only when wr_valid && wr_ready; it SHALL be stored at the write index, and the index SHALL then increment.
REQ-019 Line completion SHALL occur on an accepted word with wr_last=1, or on the PX_NUM-th accepted word regardless of wr_last.
- On completion: FSM goes to FULL; bank length = number of words accepted in that line (1..PX_NUM).
REQ-020 A zero-length line SHALL NOT exist; wr_last is meaningful only on an accepted word.
REQ-021 swap_req sampled in FULL SHALL, on that edge:
- exchange the banks;
- reset the write index to 0;
- return the FSM to FILL;
- increment line_count.
REQ-022 swap_req sampled in FILL SHALL NOT swap; it SHALL set underrun, and the read bank SHALL keep displaying its previous content.
REQ-023 If line completion and swap_req occur in the same cycle, the FSM SHALL enter FULL and underrun SHALL be set; the swap SHALL take effect on the next swap_req.
REQ-024 Read latency SHALL be exactly 1 cycle: pixel at edge N+1 reflects next_px_num and the read bank as they stand before edge N+1.
REQ-025 The read value SHALL be 0 when next_px_num >= the read bank length, or when next_px_num >= PX_NUM.
REQ-026 On a swap edge, pixel SHALL still come from the old read bank; from the next edge onward it SHALL come from the new read bank.
REQ-027 Writes SHALL never alter the read bank.
REQ-028 No combinational path SHALL run from next_px_num to pixel, or from wr_valid to wr_ready.

Reset
REQ-029 While reset_n is low, all of the following SHALL hold:
- FSM = FILL, write index = 0, read bank = bank 0 with length 0, write bank = bank 1;
- pixel = 0, line_count = 0, underrun = 0, wr_ready = 0.
REQ-030 Bank memory contents SHALL NOT need reset; a length of 0 forces black output.
REQ-031 Reset asserted mid-line SHALL discard the partial line; after release the next accepted word SHALL be written at index 0.
REQ-032 underrun SHALL be cleared only by reset.

Verification
REQ-033 Release reset; sweep next_px_num 0..47 -> pixel = 0 throughout, wr_ready = 1 one cycle after release.
REQ-034 Write 48 words (value = 0x010000 * i), wr_last on i=47; pulse swap_req; sweep next_px_num -> pixel = 0x010000 * i with 1-cycle latency; line_count = 1; wr_ready goes 0 after word 47 and returns to 1 after the swap.
REQ-035 Write 10 words 0xFFFFFF with wr_last on the 10th, then swap -> indices 0..9 read 0xFFFFFF, indices 10..47 read 0, next_px_num = 63 reads 0.
REQ-036 Pulse swap_req in FILL after one prior swap -> underrun = 1, line_count unchanged, displayed line unchanged; a later complete line plus swap still swaps and underrun stays 1.
REQ-037 Hold wr_valid=1 for 60 words without wr_last -> exactly 48 accepted, wr_ready = 0 from then until swap_req; next_px_num held at 5 across the swap edge -> old value on the swap cycle, new value one cycle later.
REQ-038 Assert reset_n low after 20 words of a line -> all outputs return to reset values asynchronously; after release a fresh 48-word line displays correctly from index 0.
